div_remainder_seq: RTL and testbench

//  Sequencer and remainder datapath of the unsigned restoring divider; sits directly downstream of the

---
 rtl/div_remainder_seq_pkg.sv | 20 ++
 rtl/div_step.sv | 33 +++
 rtl/div_remainder_seq.sv | 152 +++++++++++++++
 tb/tb_div_remainder_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_remainder_seq_pkg.sv
// rtl/div_remainder_seq_pkg.sv - shared types and constants for the sequential restoring divider
package div_remainder_seq_pkg;

    // Default operand width for quotient, remainder, dividend and divisor
    localparam int DIV_WIDTH = 32;

    // Sequencer states; encodings are fixed so other blocks can decode them
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Iteration counter width for a given operand width
    function automatic int div_count_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational shift/compare/subtract step of the restoring divider
module div_step
    import div_remainder_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] rem,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_next,
    output logic               q_bit
);

    // Trial value keeps one extra bit so the shifted-out MSB is never lost
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] lo_shift;
    logic [WIDTH-1:0] hi_sub;

    assign trial    = rem[2*WIDTH-1:WIDTH-1];
    assign lo_shift = {rem[WIDTH-2:0], 1'b0};
    // Low WIDTH bits of trial-divisor; the result always fits when trial >= divisor
    assign hi_sub   = trial[WIDTH-1:0] - divisor;

    // Restore on a failed compare, otherwise keep the difference and shift in a 1
    always_comb begin
        q_bit    = 1'b0;
        rem_next = {trial[WIDTH-1:0], lo_shift};
        if (trial >= {1'b0, divisor}) begin
            q_bit    = 1'b1;
            rem_next = {hi_sub, lo_shift[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_remainder_seq.sv
// rtl/div_remainder_seq.sv - restoring divider sequencer and remainder datapath; optional DIV_BY_ZERO_DETECT_EN
module div_remainder_seq
    import div_remainder_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             divisor_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_count_w(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    count;
    logic [2*WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] step_rem;
    logic             step_q_bit;
    logic [WIDTH-1:0] dividend_q;
    logic             accept;
    logic             last_iter;
    logic             zero_skip;

    assign accept    = (state == ST_IDLE) && start;
    assign last_iter = (state == ST_ITER) && (count == COUNT_LAST);

`ifdef DIV_BY_ZERO_DETECT_EN
    // A zero divisor is caught on the first iteration cycle, once the Divisor register has loaded
    assign zero_skip = (state == ST_ITER) && (count == '0) && (divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .divisor  (divisor),
        .rem_next (step_rem),
        .q_bit    (step_q_bit)
    );

    // State register; reset overrides any pending start or iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE -> INIT -> ITER x WIDTH -> DONE -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_INIT;
            ST_INIT: state_next = ST_ITER;
            ST_ITER: if (zero_skip || last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        divisor_we = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_INIT: begin
                divisor_we = 1'b1;
                busy       = 1'b1;
            end
            ST_ITER: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, partial remainder shifting and iteration count
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_q <= '0;
            rem        <= '0;
            count      <= '0;
        end else begin
            if (accept) begin
                dividend_q <= dividend;
            end
            case (state)
                ST_INIT: begin
                    rem   <= {{WIDTH{1'b0}}, dividend_q};
                    count <= '0;
                end
                ST_ITER: begin
                    if (!zero_skip) begin
                        rem   <= {step_rem[2*WIDTH-1:1], step_q_bit};
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: cleared by an accepted start, loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (zero_skip) begin
            quotient  <= '1;
            remainder <= rem[WIDTH-1:0];
        end else if (last_iter) begin
            quotient  <= {step_rem[WIDTH-1:1], step_q_bit};
            remainder <= step_rem[2*WIDTH-1:WIDTH];
        end
    end

`ifdef DIV_BY_ZERO_DETECT_EN
    logic div_by_zero_q;

    // Sticky zero-divisor flag, held until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero_q <= 1'b0;
        end else if (accept) begin
            div_by_zero_q <= 1'b0;
        end else if (zero_skip) begin
            div_by_zero_q <= 1'b1;
        end
    end

    assign div_by_zero = div_by_zero_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_remainder_seq.sv
// tb/tb_div_remainder_seq.sv - directed self-checking bench for div_remainder_seq
module tb_div_remainder_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor_op;
    logic [W-1:0] divisor_reg;
    logic         divisor_we;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Model of the upstream Divisor register, written only by divisor_we
    always @(posedge clk) begin
        if (divisor_we) divisor_reg <= divisor_op;
    end

    div_remainder_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor_reg),
        .divisor_we  (divisor_we),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and wait (bounded) for done; edges counts E0 as edge 1
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] d,
                           output int edges, output int we_cnt, output logic we_first,
                           output logic busy_at_done);
        dividend   = a;
        divisor_op = d;
        start      = 1'b1;
        step();
        start    = 1'b0;
        edges    = 1;
        we_cnt   = 0;
        we_first = divisor_we;
        while (!done && edges < 100) begin
            if (divisor_we) we_cnt++;
            step();
            edges++;
        end
        if (divisor_we) we_cnt++;
        busy_at_done = busy;
    endtask

    int   edges;
    int   we_cnt;
    int   done_cnt;
    int   exp_edges_dz;
    logic we_first;
    logic busy_at_done;
    logic exp_dz;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        dividend    = '0;
        divisor_op  = '0;
        divisor_reg = '0;
        step();
        step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, divisor_we}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        rst = 1'b0;
        step();

        // 1: 100 / 7
        run_div(32'd100, 32'd7, edges, we_cnt, we_first, busy_at_done);
        chk("t1_edges", edges, 32'd34);
        chk("t1_we_first", {31'b0, we_first}, 32'd1);
        chk("t1_we_cnt", we_cnt, 32'd1);
        chk("t1_busy_done", {31'b0, busy_at_done}, 32'd0);
        chk("t1_q", quotient, 32'd14);
        chk("t1_r", remainder, 32'd2);
        step();
        chk("t1_done_pulse", {31'b0, done}, 32'd0);
        chk("t1_q_hold", quotient, 32'd14);

        // 2: boundary operands
        run_div(32'hFFFFFFFF, 32'd1, edges, we_cnt, we_first, busy_at_done);
        chk("t2a_q", quotient, 32'hFFFFFFFF);
        chk("t2a_r", remainder, 32'd0);
        step();
        run_div(32'h12345678, 32'hABCDEF01, edges, we_cnt, we_first, busy_at_done);
        chk("t2b_q", quotient, 32'd0);
        chk("t2b_r", remainder, 32'h12345678);
        step();

        // 3: divide by zero
`ifdef DIV_BY_ZERO_DETECT_EN
        exp_edges_dz = 3;
        exp_dz       = 1'b1;
`else
        exp_edges_dz = 34;
        exp_dz       = 1'b0;
`endif
        run_div(32'hABCDEF01, 32'd0, edges, we_cnt, we_first, busy_at_done);
        chk("t3_edges", edges, exp_edges_dz);
        chk("t3_dbz", {31'b0, div_by_zero}, {31'b0, exp_dz});
        chk("t3_q", quotient, 32'hFFFFFFFF);
        chk("t3_r", remainder, 32'hABCDEF01);
        step();
        chk("t3_dbz_hold", {31'b0, div_by_zero}, {31'b0, exp_dz});

        // 4: extra starts during ITER and DONE are ignored
        dividend   = 32'd100;
        divisor_op = 32'd7;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("t4_dbz_clr", {31'b0, div_by_zero}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        dividend   = 32'd999;
        divisor_op = 32'd5;
        start      = 1'b1;
        step();
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40 && !done; i++) step();
        if (done) done_cnt++;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_q", quotient, 32'd14);
        chk("t4_r", remainder, 32'd2);
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            if (divisor_we) done_cnt += 100;
            step();
        end
        chk("t4_one_done", done_cnt, 32'd1);
        chk("t4_q_hold", quotient, 32'd14);
        chk("t4_r_hold", remainder, 32'd2);
        chk("t4_idle", {31'b0, busy}, 32'd0);

        // 5: reset at count=10 aborts, then 1000 / 3
        dividend   = 32'd77;
        divisor_op = 32'd4;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_q", quotient, 32'd0);
        chk("t5_r", remainder, 32'd0);
        run_div(32'd1000, 32'd3, edges, we_cnt, we_first, busy_at_done);
        chk("t5_edges", edges, 32'd34);
        chk("t5b_q", quotient, 32'd333);
        chk("t5b_r", remainder, 32'd1);
        step();

        // 6: start and rst together in IDLE
        dividend   = 32'd50;
        divisor_op = 32'd9;
        start      = 1'b1;
        rst        = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b0;
        chk("t6_busy", {31'b0, busy}, 32'd0);
        we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (divisor_we || busy) we_cnt++;
            step();
        end
        chk("t6_no_we", we_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
